// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction memory request/response port
//
// Purpose : groups the instruction-memory handshake into one bundle.
// Signals : imem_req/imem_addr   request, held until imem_gnt
//           imem_gnt             request accepted this cycle
//           imem_rvalid          read response valid
//           imem_rdata/imem_err  response data and error, qualified by imem_rvalid
// Modports: master (fetch unit side), slave (memory side)
interface ifetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic              imem_err;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata, imem_err
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata, imem_err
   );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-outstanding instruction fetch responder
//
// Purpose : fetches the word at curr_pc over the imem port and hands it to the
//           datapath with a one-cycle inst_ready pulse that advances the PC.
//           Handles flush (drop of in-flight response), misaligned PCs and
//           bus errors (sticky fault until flush).
// Ports   : clk, nrst          clock, async active-low reset
//           curr_pc            fetch address
//           dp_ready, flush    datapath accept / pipeline flush
//           inst_ready, inst, inst_addr   delivered instruction
//           fault, fault_addr  latched fetch fault
//           imem               memory port (master side)
module ifetch_unit #(
   parameter int                ADDR_W  = 32,
   parameter int                DATA_W  = 32,
   parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [ADDR_W-1:0] curr_pc,
   input  logic              dp_ready,
   input  logic              flush,
   output logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_addr,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   ifetch_unit_if.master     imem
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FAULT = 3'd4
   } state_t;

   state_t            state_q;
   logic              drop_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] buf_q;
   logic              fault_q;
   logic [ADDR_W-1:0] fault_addr_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= IDLE;
         drop_q       <= 1'b0;
         addr_q       <= PC_INIT;
         buf_q        <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= PC_INIT;
      end else begin
         case (state_q)
            IDLE: begin
               if (!flush) begin
                  addr_q <= curr_pc;
                  if (curr_pc[1:0] != 2'b00) begin
                     fault_q      <= 1'b1;
                     fault_addr_q <= curr_pc;
                     state_q      <= FAULT;
                  end else begin
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               // A request cannot be retracted; a flush only marks its
               // response for discard.
               if (flush) drop_q <= 1'b1;
               if (imem.imem_gnt) state_q <= WAIT;
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  // A flush arriving with the response discards it directly,
                  // otherwise the FSM would wait for a response that never comes.
                  if (drop_q || flush) begin
                     drop_q  <= 1'b0;
                     state_q <= IDLE;
                  end else if (imem.imem_err) begin
                     fault_q      <= 1'b1;
                     fault_addr_q <= addr_q;
                     state_q      <= FAULT;
                  end else if (dp_ready) begin
                     state_q <= IDLE;
                  end else begin
                     buf_q   <= imem.imem_rdata;
                     state_q <= HOLD;
                  end
               end else if (flush) begin
                  drop_q <= 1'b1;
               end
            end
            HOLD: begin
               if (flush || dp_ready) state_q <= IDLE;
            end
            FAULT: begin
               if (flush) begin
                  fault_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      inst_ready = 1'b0;
      if (!flush) begin
         if (state_q == WAIT)
            inst_ready = imem.imem_rvalid && !drop_q && !imem.imem_err && dp_ready;
         else if (state_q == HOLD)
            inst_ready = dp_ready;
      end
   end

   assign inst       = (state_q == HOLD) ? buf_q : imem.imem_rdata;
   assign inst_addr  = addr_q;
   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = addr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit
module tb_ifetch_unit;

   logic        clk;
   logic        nrst;
   logic [31:0] curr_pc;
   logic        dp_ready;
   logic        flush;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        fault;
   logic [31:0] fault_addr;

   int total;
   int bad;

   ifetch_unit_if #(.ADDR_W(32), .DATA_W(32)) imem ();

   ifetch_unit #(.ADDR_W(32), .DATA_W(32), .PC_INIT(32'h0)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .curr_pc    (curr_pc),
      .dp_ready   (dp_ready),
      .flush      (flush),
      .inst_ready (inst_ready),
      .inst       (inst),
      .inst_addr  (inst_addr),
      .fault      (fault),
      .fault_addr (fault_addr),
      .imem       (imem.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        dr, fl, gnt, rv, er;
      logic [31:0] rd;
      logic        e_rdy, e_req;
      logic [31:0] e_addr, e_inst;
      logic        e_flt;
      logic [31:0] e_faddr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] pc, input logic dr, fl, gnt, rv, er,
                      input logic [31:0] rd, input logic e_rdy, e_req,
                      input logic [31:0] e_addr, e_inst, input logic e_flt,
                      input logic [31:0] e_faddr);
      vec_t v;
      v.pc = pc; v.dr = dr; v.fl = fl; v.gnt = gnt; v.rv = rv; v.er = er; v.rd = rd;
      v.e_rdy = e_rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_inst = e_inst;
      v.e_flt = e_flt; v.e_faddr = e_faddr;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic dr, fl, gnt, rv, er,
                        input logic [31:0] rd);
      curr_pc = pc; dp_ready = dr; flush = fl;
      imem.imem_gnt = gnt; imem.imem_rvalid = rv; imem.imem_err = er; imem.imem_rdata = rd;
   endtask

   initial begin
      bit found;
      int cycles;
      total = 0;
      bad   = 0;
      nrst  = 1'b0;
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      //   pc          dr fl gt rv er rdata          rdy req addr          inst          flt faddr
      // basic fetch at 0, then PC advances to 4
      add(32'h000,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h000,     1, 0, 1, 0, 0, 32'h0,         0, 1, 32'h0,   32'h0,         0, 32'h0);
      add(32'h000,     1, 0, 0, 1, 0, 32'h13,        1, 0, 32'h0,   32'h13,        0, 32'h0);
      add(32'h004,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h004,     1, 0, 1, 0, 0, 32'h0,         0, 1, 32'h4,   32'h0,         0, 32'h0);
      add(32'h004,     1, 0, 0, 1, 0, 32'h11,        1, 0, 32'h4,   32'h11,        0, 32'h0);
      // grant delayed 3 cycles (rvalid before grant ignored), then hold 2 cycles
      add(32'h100,     0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h100,     0, 0, 0, 0, 0, 32'h0,         0, 1, 32'h100, 32'h0,         0, 32'h0);
      add(32'h100,     0, 0, 0, 1, 0, 32'hBAD0,      0, 1, 32'h100, 32'h0,         0, 32'h0);
      add(32'h100,     0, 0, 0, 0, 0, 32'h0,         0, 1, 32'h100, 32'h0,         0, 32'h0);
      add(32'h100,     0, 0, 1, 0, 0, 32'h0,         0, 1, 32'h100, 32'h0,         0, 32'h0);
      add(32'h100,     0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h100,     0, 0, 0, 1, 0, 32'hDEADBEEF,  0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h100,     0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h100,     1, 0, 0, 0, 0, 32'h0,         1, 0, 32'h100, 32'hDEADBEEF,  0, 32'h0);
      // flush in WAIT: response dropped, refetch from redirected PC
      add(32'h104,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h104,     1, 0, 1, 0, 0, 32'h0,         0, 1, 32'h104, 32'h0,         0, 32'h0);
      add(32'h104,     1, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h200,     1, 0, 0, 1, 0, 32'h12345678,  0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h200,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h200,     1, 0, 1, 0, 0, 32'h0,         0, 1, 32'h200, 32'h0,         0, 32'h0);
      // bus error at 0x200: sticky fault, no requests, flush resumes
      add(32'h200,     1, 0, 0, 1, 1, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h200,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h200);
      add(32'h200,     1, 0, 1, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h200);
      add(32'h200,     1, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h200);
      add(32'h300,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h300,     1, 0, 1, 0, 0, 32'h0,         0, 1, 32'h300, 32'h0,         0, 32'h0);
      add(32'h300,     1, 0, 0, 1, 0, 32'hAAAA0001,  1, 0, 32'h300, 32'hAAAA0001,  0, 32'h0);
      // misaligned PC: fault without any request
      add(32'h102,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h102,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h102);
      add(32'h102,     1, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h102);
      add(32'h400,     1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
      add(32'h400,     1, 0, 1, 0, 0, 32'h0,         0, 1, 32'h400, 32'h0,         0, 32'h0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      #1;
      check("reset_inst_ready", -1, {31'b0, inst_ready}, 32'h0);
      check("reset_imem_req",   -1, {31'b0, imem.imem_req}, 32'h0);
      check("reset_fault",      -1, {31'b0, fault}, 32'h0);
      check("reset_fault_addr", -1, fault_addr, 32'h0);
      check("reset_imem_addr",  -1, imem.imem_addr, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].pc, vecs[i].dr, vecs[i].fl, vecs[i].gnt, vecs[i].rv, vecs[i].er, vecs[i].rd);
         #1;
         check("inst_ready", i, {31'b0, inst_ready}, {31'b0, vecs[i].e_rdy});
         check("imem_req",   i, {31'b0, imem.imem_req}, {31'b0, vecs[i].e_req});
         check("fault",      i, {31'b0, fault}, {31'b0, vecs[i].e_flt});
         if (vecs[i].e_req) check("imem_addr", i, imem.imem_addr, vecs[i].e_addr);
         if (vecs[i].e_rdy) begin
            check("inst",      i, inst, vecs[i].e_inst);
            check("inst_addr", i, inst_addr, vecs[i].e_addr);
         end
         if (vecs[i].e_flt) check("fault_addr", i, fault_addr, vecs[i].e_faddr);
         @(posedge clk);
         #1;
      end

      // Now in WAIT for 0x400: async reset mid-transaction
      drive(32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      nrst = 1'b0;
      #1;
      check("midwait_rst_req",       100, {31'b0, imem.imem_req}, 32'h0);
      check("midwait_rst_fault",     100, {31'b0, fault}, 32'h0);
      check("midwait_rst_ready",     100, {31'b0, inst_ready}, 32'h0);
      check("midwait_rst_inst_addr", 100, inst_addr, 32'h0);
      check("midwait_rst_faddr",     100, fault_addr, 32'h0);

      // After reset: grant and response always offered; fetch 0x8 within a bound
      @(negedge clk);
      nrst = 1'b1;
      drive(32'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE0008);
      found  = 1'b0;
      cycles = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         #1;
         if (inst_ready) begin
            found  = 1'b1;
            cycles = k;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      check("post_rst_fetch_seen", 101, {31'b0, found}, 32'h1);
      check("post_rst_latency",    101, cycles, 32'd2);
      check("post_rst_inst",       101, inst, 32'hCAFE0008);
      check("post_rst_inst_addr",  101, inst_addr, 32'h8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch responder for the PC register. It takes the current fetch address `curr_pc`, runs one request/response transaction on the instruction memory port, and returns the instruction word to the datapath. It asserts `inst_ready` for exactly one cycle when the word is delivered and consumed; that pulse is what advances the PC. It also handles pipeline flushes, misaligned PCs and bus errors.

Parameters:
ADDR_W, 32, width of fetch address and memory address
DATA_W, 32, width of instruction word and memory read data
PC_INIT, 32'b0, value of inst_addr/fault_addr at reset

Ports:
clk  in  1  system clock, all state on rising edge
nrst  in  1  asynchronous active-low reset
curr_pc  in  ADDR_W  fetch address from PC; stable until the cycle after inst_ready
dp_ready  in  1  datapath can consume an instruction this cycle
flush  in  1  discard any pending/buffered fetch (trap, redirect)
inst_ready  out  1  one-cycle pulse: inst valid and consumed; PC advances
inst  out  DATA_W  fetched instruction, valid when inst_ready
inst_addr  out  ADDR_W  address of inst
imem_req  out  1  memory request
imem_addr  out  ADDR_W  request address, = addr_q
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read response valid
imem_rdata  in  DATA_W  read data
imem_err  in  1  response error, qualified by imem_rvalid
fault  out  1  fetch fault latched
fault_addr  out  ADDR_W  address that faulted

Behaviour:
- Reset (async, nrst=0): state=IDLE, drop=0, addr_q=PC_INIT, buf=0, fault=0, fault_addr=PC_INIT, inst_ready=0, imem_req=0.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE:
  - addr_q<=curr_pc.
  - If curr_pc[1:0]!=0, go FAULT: fault_addr<=curr_pc, no request issued.
  - Otherwise go REQ.
- REQ:
  - imem_req=1, imem_addr=addr_q, held stable until imem_gnt.
  - gnt goes WAIT; no gnt stays in REQ.
- WAIT (imem_req=0; rvalid before gnt is ignored):
  - rvalid && drop: discard response, drop<=0, go IDLE.
  - rvalid && err: go FAULT, fault_addr<=addr_q.
  - rvalid && dp_ready: pass-through; inst=imem_rdata, inst_addr=addr_q, inst_ready=1, go IDLE.
  - rvalid && !dp_ready: buf<=imem_rdata, go HOLD.
- HOLD:
  - inst=buf, inst_addr=addr_q.
  - dp_ready: inst_ready=1, go IDLE. Otherwise hold.
- FAULT:
  - fault=1, inst_ready=0, no requests.
  - Exit only via flush, which clears fault and goes IDLE.
- flush (synchronous, priority over all but reset):
  - IDLE/HOLD/FAULT: go IDLE; buffered word lost; inst_ready forced 0 that cycle.
  - REQ: request stays asserted until gnt (no retraction); drop<=1.
  - WAIT: drop<=1.
  - While drop=1: inst_ready=0, and imem_err does not raise fault.
- inst_ready is combinational from state/rvalid/dp_ready/flush. It is never high in two consecutive cycles, because IDLE always separates fetches.
- Latency with gnt in REQ and rvalid the next cycle: curr_pc sampled at IDLE (cycle 0), req at cycle 1, inst_ready at cycle 2. Steady-state throughput is 1 instruction per 3 cycles.
- Single outstanding transaction. A second request is never issued before the response for the first.
- inst/inst_addr are don't-care when inst_ready=0, but must hold buf/addr_q in HOLD.

Test Plan:
- Reset, curr_pc=0, gnt in REQ, rvalid next cycle with rdata=0x00000013, dp_ready=1 -> imem_addr=0x0 at cycle 1; inst_ready=1, inst=0x13, inst_addr=0x0 at cycle 2; next request addr=0x4 once PC advances.
- gnt delayed 3 cycles, addr=0x100 -> imem_req high 4 cycles, imem_addr stable at 0x100; exactly one request.
- rvalid while dp_ready=0 for 2 cycles, rdata=0xDEADBEEF -> HOLD; inst_ready=0 during the hold, then a 1-cycle pulse with inst=0xDEADBEEF.
- flush asserted in WAIT, later rvalid with rdata=0x12345678 -> word dropped, no inst_ready, new fetch from current curr_pc.
- rvalid with err=1 at addr 0x200 -> fault=1, fault_addr=0x200, no further imem_req; flush -> fault=0, fetch resumes.
- curr_pc=0x00000102 -> FAULT with no imem_req and fault_addr=0x102. Separately, nrst low mid-WAIT -> all outputs return to reset values immediately.
